// File: rtl/id_fwd_stage_pkg.sv
// Shared decode constants for the MIPS ID stage with operand bypass.
// Covers the logic subset: ORI/ANDI/XORI/LUI and SPECIAL AND/OR/XOR/NOR.
package id_fwd_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;

  localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP  = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP = 8'b00100111;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;

  localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

  typedef enum logic [1:0] {
    INST_ITYPE,
    INST_LUI,
    INST_RTYPE,
    INST_INVALID
  } inst_class_e;

  // The low two bits of both the I-type opcodes and the SPECIAL functs pick AND/OR/XOR/NOR.
  function automatic logic [7:0] logic_aluop(input logic [1:0] sel);
    case (sel)
      2'b00:   return EXE_AND_OP;
      2'b01:   return EXE_OR_OP;
      2'b10:   return EXE_XOR_OP;
      default: return EXE_NOR_OP;
    endcase
  endfunction

endpackage

// File: rtl/id_fwd_stage_if.sv
// Bundle of the ID stage's handshake, regfile and bypass signals.
// slave is the decode stage itself; master is whatever drives it (pipeline glue or a bench).
interface id_fwd_stage_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_FWD  = 2,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) ();

  logic                        in_valid_i;
  logic                        in_ready_o;
  logic [31:0]                 pc_i;
  logic [31:0]                 inst_i;
  logic                        flush_i;
  logic [ADDR_W-1:0]           reg1_addr_o;
  logic [ADDR_W-1:0]           reg2_addr_o;
  logic                        reg1_read_o;
  logic                        reg2_read_o;
  logic [DATA_W-1:0]           reg1_data_i;
  logic [DATA_W-1:0]           reg2_data_i;
  logic [NUM_FWD-1:0]          fwd_wreg_i;
  logic [NUM_FWD-1:0]          fwd_load_i;
  logic [NUM_FWD*ADDR_W-1:0]   fwd_waddr_i;
  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [ALUOP_W-1:0]          aluop_o;
  logic [ALUSEL_W-1:0]         alusel_o;
  logic [DATA_W-1:0]           reg1_o;
  logic [DATA_W-1:0]           reg2_o;
  logic [ADDR_W-1:0]           waddr_o;
  logic                        wreg_o;
  logic [31:0]                 pc_o;
  logic                        instvalid_o;
  logic                        stall_req_o;

  modport slave (
    input  in_valid_i, pc_i, inst_i, flush_i, reg1_data_i, reg2_data_i,
           fwd_wreg_i, fwd_load_i, fwd_waddr_i, fwd_wdata_i, out_ready_i,
    output in_ready_o, reg1_addr_o, reg2_addr_o, reg1_read_o, reg2_read_o,
           out_valid_o, aluop_o, alusel_o, reg1_o, reg2_o, waddr_o, wreg_o,
           pc_o, instvalid_o, stall_req_o
  );

  modport master (
    output in_valid_i, pc_i, inst_i, flush_i, reg1_data_i, reg2_data_i,
           fwd_wreg_i, fwd_load_i, fwd_waddr_i, fwd_wdata_i, out_ready_i,
    input  in_ready_o, reg1_addr_o, reg2_addr_o, reg1_read_o, reg2_read_o,
           out_valid_o, aluop_o, alusel_o, reg1_o, reg2_o, waddr_o, wreg_o,
           pc_o, instvalid_o, stall_req_o
  );

endinterface

// File: rtl/id_fwd_stage_mux.sv
// Operand select for one read port: immediate, hard-wired $0, youngest matching bypass, or regfile.
// Also reports when the chosen bypass source is a load whose data is not ready yet.
module id_fwd_mux
  import id_fwd_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                      read_en,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         imm,
  input  logic [DATA_W-1:0]         reg_data,
  input  logic [NUM_FWD-1:0]        fwd_wreg,
  input  logic [NUM_FWD-1:0]        fwd_load,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  output logic [DATA_W-1:0]         operand,
  output logic                      load_hit
);

  logic [DATA_W-1:0] bypass;
  logic              bypass_load;

  // Walk from oldest to youngest so the lowest-index match wins, including its load flag.
  always_comb begin
    bypass      = reg_data;
    bypass_load = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_wreg[k] && (fwd_waddr[k*ADDR_W +: ADDR_W] == addr)) begin
        bypass      = fwd_wdata[k*DATA_W +: DATA_W];
        bypass_load = fwd_load[k];
      end
    end
  end

  always_comb begin
    operand  = bypass;
    load_hit = 1'b0;
    if (read_en != READ_ENABLE) begin
      operand = imm;
    end else if (addr == '0) begin
      operand = '0;
    end else begin
      load_hit = bypass_load;
    end
  end

endmodule

// File: rtl/id_fwd_stage.sv
// MIPS decode stage: logic-op decode, bypassed operand fetch, load-use stall
// and a valid/ready ID/EX output register.
module id_fwd_stage
  import id_fwd_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_FWD  = 2,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  id_fwd_stage_if.slave   bus
);

  logic [5:0]          op;
  logic [5:0]          funct;
  logic [15:0]         imm16;
  logic [4:0]          unused_shamt;
  inst_class_e         inst_class;
  logic [ALUOP_W-1:0]  dec_aluop;
  logic [ALUSEL_W-1:0] dec_alusel;
  logic [ADDR_W-1:0]   dec_waddr;
  logic                dec_wreg;
  logic                dec_valid;
  logic                read1;
  logic                read2;
  logic [DATA_W-1:0]   imm;
  logic [DATA_W-1:0]   operand1;
  logic [DATA_W-1:0]   operand2;
  logic                load1;
  logic                load2;
  logic                stall;
  logic                accept;

  assign op           = bus.inst_i[31:26];
  assign funct        = bus.inst_i[5:0];
  assign imm16        = bus.inst_i[15:0];
  assign unused_shamt = bus.inst_i[10:6];

  always_comb begin
    inst_class = INST_INVALID;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: inst_class = INST_ITYPE;
      OP_LUI:                   inst_class = INST_LUI;
      OP_SPECIAL: begin
        if (funct inside {FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR}) inst_class = INST_RTYPE;
      end
      default: ;
    endcase
  end

  // Undecodable words fall through the defaults and travel on as a non-writing NOP.
  always_comb begin
    dec_aluop  = ALUOP_W'(EXE_NOP_OP);
    dec_alusel = ALUSEL_W'(EXE_RES_NOP);
    dec_waddr  = ADDR_W'(NOP_REG_ADDR);
    dec_wreg   = WRITE_DISABLE;
    dec_valid  = 1'b0;
    read1      = READ_DISABLE;
    read2      = READ_DISABLE;
    imm        = DATA_W'(imm16);
    case (inst_class)
      INST_ITYPE: begin
        dec_aluop  = ALUOP_W'(logic_aluop(op[1:0]));
        dec_alusel = ALUSEL_W'(EXE_RES_LOGIC);
        dec_waddr  = ADDR_W'(bus.inst_i[20:16]);
        dec_wreg   = WRITE_ENABLE;
        dec_valid  = 1'b1;
        read1      = READ_ENABLE;
      end
      INST_LUI: begin
        dec_aluop  = ALUOP_W'(EXE_OR_OP);
        dec_alusel = ALUSEL_W'(EXE_RES_LOGIC);
        dec_waddr  = ADDR_W'(bus.inst_i[20:16]);
        dec_wreg   = WRITE_ENABLE;
        dec_valid  = 1'b1;
        read1      = READ_ENABLE;
        imm        = DATA_W'({imm16, 16'h0000});
      end
      INST_RTYPE: begin
        dec_aluop  = ALUOP_W'(logic_aluop(funct[1:0]));
        dec_alusel = ALUSEL_W'(EXE_RES_LOGIC);
        dec_waddr  = ADDR_W'(bus.inst_i[15:11]);
        dec_wreg   = WRITE_ENABLE;
        dec_valid  = 1'b1;
        read1      = READ_ENABLE;
        read2      = READ_ENABLE;
      end
      default: ;
    endcase
  end

  assign bus.reg1_addr_o = ADDR_W'(bus.inst_i[25:21]);
  assign bus.reg2_addr_o = ADDR_W'(bus.inst_i[20:16]);
  assign bus.reg1_read_o = read1;
  assign bus.reg2_read_o = read2;

  id_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD)) u_mux1 (
    .read_en   (read1),
    .addr      (bus.reg1_addr_o),
    .imm       (imm),
    .reg_data  (bus.reg1_data_i),
    .fwd_wreg  (bus.fwd_wreg_i),
    .fwd_load  (bus.fwd_load_i),
    .fwd_waddr (bus.fwd_waddr_i),
    .fwd_wdata (bus.fwd_wdata_i),
    .operand   (operand1),
    .load_hit  (load1)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD)) u_mux2 (
    .read_en   (read2),
    .addr      (bus.reg2_addr_o),
    .imm       (imm),
    .reg_data  (bus.reg2_data_i),
    .fwd_wreg  (bus.fwd_wreg_i),
    .fwd_load  (bus.fwd_load_i),
    .fwd_waddr (bus.fwd_waddr_i),
    .fwd_wdata (bus.fwd_wdata_i),
    .operand   (operand2),
    .load_hit  (load2)
  );

  assign stall           = bus.in_valid_i && (load1 || load2);
  assign bus.stall_req_o = stall;
  assign bus.in_ready_o  = (!bus.out_valid_o || bus.out_ready_i) && !stall && !bus.flush_i;
  assign accept          = bus.in_valid_i && bus.in_ready_o;

  // Flush beats accept; a consumed bundle with nothing new behind it leaves a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      bus.out_valid_o <= 1'b0;
      bus.aluop_o     <= ALUOP_W'(EXE_NOP_OP);
      bus.alusel_o    <= ALUSEL_W'(EXE_RES_NOP);
      bus.reg1_o      <= '0;
      bus.reg2_o      <= '0;
      bus.waddr_o     <= ADDR_W'(NOP_REG_ADDR);
      bus.wreg_o      <= WRITE_DISABLE;
      bus.pc_o        <= ZERO_WORD;
      bus.instvalid_o <= 1'b1;
    end else if (bus.flush_i) begin
      bus.out_valid_o <= 1'b0;
    end else if (accept) begin
      bus.out_valid_o <= 1'b1;
      bus.aluop_o     <= dec_aluop;
      bus.alusel_o    <= dec_alusel;
      bus.reg1_o      <= operand1;
      bus.reg2_o      <= operand2;
      bus.waddr_o     <= dec_waddr;
      bus.wreg_o      <= dec_wreg;
      bus.pc_o        <= bus.pc_i;
      bus.instvalid_o <= dec_valid;
    end else if (bus.out_ready_i) begin
      bus.out_valid_o <= 1'b0;
    end
  end

endmodule
